// File: rtl/lcm_res_fifo.sv
// lcm_res_fifo: first-word-fall-through buffer for lcm/gcd result pairs.
// The engine upstream cannot be stalled. Any result that arrives while the
// buffer is full and is not making room is counted as dropped.
module lcm_res_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_W-1:0]     lcm_in,
    input  logic [DATA_W-1:0]       mcd_in,
    input  logic                    vld_in,
    output logic [2*DATA_W-1:0]     out_lcm,
    output logic [DATA_W-1:0]       out_mcd,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    ovf,
    input  logic                    ovf_clr,
    output logic [7:0]              drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 3 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [7:0]       DROP_MAX = 8'hFF;

    // Each entry is packed as {lcm, mcd}.
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             full_w;
    logic             empty_w;
    logic             pop;
    logic             push;
    logic             drop;
    logic [ENT_W-1:0] head;

    // Handshake decode. A pop in the same cycle frees a slot for a push while full.
    always_comb begin
        full_w  = (count_q == CNT_FULL);
        empty_w = (count_q == '0);
        pop     = !empty_w && out_rdy;
        push    = vld_in && (!full_w || pop);
        drop    = vld_in && full_w && !pop;
    end

    // Storage write. Dropped results never touch the array.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {lcm_in, mcd_in};
        end
    end

    // Pointer and occupancy next-state. Pointers wrap naturally at DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Overflow tracking. A drop in the same cycle as a clear takes priority.
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array is not reset. The output mux hides stale contents while empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    // Head entry is shown directly from the array. Outputs are zero while empty.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_vld  = !empty_w;
        out_lcm  = empty_w ? '0 : head[ENT_W-1:DATA_W];
        out_mcd  = empty_w ? '0 : head[DATA_W-1:0];
        count    = count_q;
        full     = full_w;
        empty    = empty_w;
        ovf      = ovf_q;
        drop_cnt = drop_cnt_q;
    end

endmodule
